// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: CPU (C) has fixed priority,
// a streak counter guarantees the DMA port (D) a slot after MAX_STREAK CPU wins.
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic [31:0] c_rdata,
  output logic        c_rvalid,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,

  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rd_data
);

  localparam logic [31:0] ADDR_MASK =
    (ADDR_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ADDR_W) - 64'd1);
  localparam logic [7:0] STREAK_LIMIT = 8'(MAX_STREAK);

  typedef enum logic {OWNER_C, OWNER_D} owner_t;

  logic [7:0] streak;
  owner_t     owner;
  logic       c_xfer;
  logic       d_xfer;

  // Once the CPU has used up its streak while D waits, D wins the next slot.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (streak == STREAK_LIMIT && d_req) begin
        d_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  assign c_xfer = c_req & c_gnt;
  assign d_xfer = d_req & d_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      owner     <= OWNER_C;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      if (c_xfer) begin
        mem_addr  <= c_addr & ADDR_MASK;
        mem_we    <= c_we;
        mem_re    <= ~c_we;
        mem_wdata <= c_wdata;
        owner     <= OWNER_C;
      end else if (d_xfer) begin
        mem_addr  <= d_addr & ADDR_MASK;
        mem_we    <= d_we;
        mem_re    <= ~d_we;
        mem_wdata <= d_wdata;
        owner     <= OWNER_D;
      end
    end
  end

  // mem_re doubles as the in-flight is_read flag; data lands at the end of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata  <= '0;
      d_rdata  <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      c_rvalid <= mem_re && (owner == OWNER_C);
      d_rvalid <= mem_re && (owner == OWNER_D);
      if (mem_re && owner == OWNER_C) begin
        c_rdata <= mem_rd_data;
      end
      if (mem_re && owner == OWNER_D) begin
        d_rdata <= mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (d_xfer || !d_req) begin
      streak <= '0;
    end else if (c_xfer && streak != STREAK_LIMIT) begin
      streak <= streak + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table plus hand-written sequences and a randomized scoreboard run
// for dmem_arbiter, with a small negedge-acting memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rd_data = 32'h0;

  int pass_cnt  = 0;
  int check_cnt = 0;

  dmem_arbiter #(.ADDR_W(16), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acts on the low phase; initial contents are 0x1000_0000 + index.
  logic [31:0] mem [0:255];
  logic        mem_loaded = 1'b0;
  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rd_data <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        e_cg, e_dg, e_re, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
  endtask

  task automatic idleInputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  // Random-traffic scoreboard state
  logic [31:0] shadow [0:15];
  logic [31:0] c_q [$];
  logic [31:0] d_q [$];
  int excl_viol = 0, idle_viol = 0, gnt_viol = 0, data_err = 0;
  int c_reads = 0, d_reads = 0, c_rv = 0, d_rv = 0;
  int streak_m = 0;
  logic prev_xfer = 1'b0;

  task automatic sampleOutputs();
    logic [31:0] e;
    if (mem_re & mem_we) excl_viol++;
    if (!prev_xfer && (mem_re | mem_we)) idle_viol++;
    if (prev_xfer && (mem_re == mem_we)) idle_viol++;
    if (c_rvalid) begin
      c_rv++;
      if (c_q.size() == 0) data_err++;
      else begin e = c_q.pop_front(); if (c_rdata !== e) data_err++; end
    end
    if (d_rvalid) begin
      d_rv++;
      if (d_q.size() == 0) data_err++;
      else begin e = d_q.pop_front(); if (d_rdata !== e) data_err++; end
    end
  endtask

  initial begin
    logic c_pend, d_pend, exp_c, exp_d, cx, dx;

    // {c_req,c_we,c_addr,c_wdata, d_req,d_we,d_addr,d_wdata,
    //  e_cg,e_dg, e_re,e_we,e_addr,e_wdata, e_crv,e_crd, e_drv,e_drd}
    vecs[0]  = '{1'b1,1'b1,32'h0000_0010,32'hDEAD_BEEF, 1'b0,1'b0,32'h0,32'h0,
                 1'b1,1'b0, 1'b0,1'b1,32'h10,32'hDEAD_BEEF, 1'b0,32'h0, 1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,32'h0000_0010,32'h0, 1'b0,1'b0,32'h0,32'h0,
                 1'b1,1'b0, 1'b1,1'b0,32'h10,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
                 1'b0,1'b0, 1'b0,1'b0,32'h10,32'h0, 1'b1,32'hDEAD_BEEF, 1'b0,32'h0};
    vecs[3]  = '{1'b1,1'b0,32'h0000_0020,32'h1111_1111, 1'b1,1'b0,32'h0000_0030,32'h0,
                 1'b1,1'b0, 1'b1,1'b0,32'h20,32'h1111_1111, 1'b0,32'hDEAD_BEEF, 1'b0,32'h0};
    vecs[4]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h0000_0030,32'h0,
                 1'b0,1'b1, 1'b1,1'b0,32'h30,32'h0, 1'b1,32'h1000_0020, 1'b0,32'h0};
    vecs[5]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
                 1'b0,1'b0, 1'b0,1'b0,32'h30,32'h0, 1'b0,32'h1000_0020, 1'b1,32'h1000_0030};
    vecs[6]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'hFFFF_0003,32'h0,
                 1'b0,1'b1, 1'b1,1'b0,32'h3,32'h0, 1'b0,32'h1000_0020, 1'b0,32'h1000_0030};
    vecs[7]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h0000_0040,32'h1234_5678,
                 1'b0,1'b1, 1'b0,1'b1,32'h40,32'h1234_5678, 1'b0,32'h1000_0020, 1'b1,32'h1000_0003};
    vecs[8]  = '{1'b1,1'b1,32'hABCD_0044,32'hCAFE_F00D, 1'b0,1'b0,32'h0,32'h0,
                 1'b1,1'b0, 1'b0,1'b1,32'h44,32'hCAFE_F00D, 1'b0,32'h1000_0020, 1'b0,32'h1000_0003};
    vecs[9]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h0000_0040,32'h0,
                 1'b0,1'b1, 1'b1,1'b0,32'h40,32'h0, 1'b0,32'h1000_0020, 1'b0,32'h1000_0003};
    vecs[10] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0,
                 1'b0,1'b0, 1'b0,1'b0,32'h40,32'h0, 1'b0,32'h1000_0020, 1'b1,32'h1234_5678};

    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset strobes", {30'b0, mem_re, mem_we}, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset rvalid", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    checkOutput("reset rdata", c_rdata | d_rdata, 32'h0);
    rst_n = 1'b1;

    // Directed table: one vector per cycle, grants checked in-cycle, issue/response after the edge
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d gnt", i), {30'b0, c_gnt, d_gnt}, {30'b0, vecs[i].e_cg, vecs[i].e_dg});
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("v%0d re/we", i), {30'b0, mem_re, mem_we}, {30'b0, vecs[i].e_re, vecs[i].e_we});
      checkOutput($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      checkOutput($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      checkOutput($sformatf("v%0d rvalid", i), {30'b0, c_rvalid, d_rvalid}, {30'b0, vecs[i].e_crv, vecs[i].e_drv});
      checkOutput($sformatf("v%0d c_rdata", i), c_rdata, vecs[i].e_crd);
      checkOutput($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_drd);
    end

    // Starvation: both ports request continuously -> C,C,C,C,D repeating
    for (int i = 0; i < 10; i++) begin
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h50; c_wdata = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; d_wdata = 32'h0;
      #1;
      checkOutput($sformatf("starve gnt %0d", i), {30'b0, c_gnt, d_gnt},
                  (i % 5 == 4) ? 32'h1 : 32'h2);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("starve streak %0d", i), {31'b0, dut.streak <= 8'd4}, 32'h1);
    end
    idleInputs();
    repeat (3) @(negedge clk);

    // Reset asserted while a read is in flight
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h70; c_wdata = 32'h5555_AAAA;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst mem_re", {31'b0, mem_re}, 32'h0);
    checkOutput("midrst mem_addr", mem_addr, 32'h0);
    checkOutput("midrst mem_wdata", mem_wdata, 32'h0);
    checkOutput("midrst rdata", c_rdata | d_rdata, 32'h0);
    checkOutput("midrst c_gnt", {31'b0, c_gnt}, 32'h0);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("postrst %0d rvalid/re", i), {30'b0, c_rvalid, mem_re}, 32'h0);
    end

    // Randomized traffic with a grant-order shadow memory scoreboard
    for (int i = 0; i < 16; i++) shadow[i] = 32'h1000_0000 + 32'(i);
    c_pend = 1'b0; d_pend = 1'b0; streak_m = 0; prev_xfer = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      sampleOutputs();
      if (!c_pend) begin
        if ($urandom_range(0, 99) < 60) begin
          c_pend = 1'b1; c_we = 1'($urandom_range(0, 1));
          c_addr = {16'($urandom), 12'h0, 4'($urandom_range(0, 15))};
          c_wdata = $urandom;
        end
      end else if ($urandom_range(0, 99) < 5) c_pend = 1'b0;
      if (!d_pend) begin
        if ($urandom_range(0, 99) < 60) begin
          d_pend = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = {16'($urandom), 12'h0, 4'($urandom_range(0, 15))};
          d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 99) < 5) d_pend = 1'b0;
      c_req = c_pend;
      d_req = d_pend;
      #1;
      exp_d = d_req && (streak_m == 4 || !c_req);
      exp_c = c_req && !(streak_m == 4 && d_req);
      if ({c_gnt, d_gnt} !== {exp_c, exp_d}) gnt_viol++;
      cx = c_req & c_gnt;
      dx = d_req & d_gnt;
      if (cx) begin
        if (c_we) shadow[c_addr[3:0]] = c_wdata;
        else begin c_q.push_back(shadow[c_addr[3:0]]); c_reads++; end
        c_pend = 1'b0;
      end
      if (dx) begin
        if (d_we) shadow[d_addr[3:0]] = d_wdata;
        else begin d_q.push_back(shadow[d_addr[3:0]]); d_reads++; end
        d_pend = 1'b0;
      end
      if (dx || !d_req) streak_m = 0;
      else if (cx && streak_m < 4) streak_m++;
      prev_xfer = cx | dx;
      @(posedge clk);
      @(negedge clk);
    end
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      sampleOutputs();
      prev_xfer = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rand re&we exclusive", 32'(excl_viol), 32'h0);
    checkOutput("rand idle/strobe", 32'(idle_viol), 32'h0);
    checkOutput("rand grant pattern", 32'(gnt_viol), 32'h0);
    checkOutput("rand read data", 32'(data_err), 32'h0);
    checkOutput("rand c rvalid count", 32'(c_rv), 32'(c_reads));
    checkOutput("rand d rvalid count", 32'(d_rv), 32'(d_reads));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported data memory. It shares the memory between the CPU load/store path (port C) and the DMA/display fetch engine (port D), and registers one command per cycle onto the memory's address/re/we/write-data pins. Read data is captured into the owning requester's port one cycle after issue. CPU has fixed priority, and a streak counter guarantees the DMA port forward progress.

## Interface
- ADDR_W, 16: memory index width; mem_addr upper bits are zero.
- MAX_STREAK, 4: consecutive CPU transfers allowed while D is waiting (range 1..255).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- c_req  in  1  CPU request valid; held with its fields until c_gnt.
- c_we  in  1  1 = write, 0 = read.
- c_addr  in  32  CPU word address; bits above ADDR_W are ignored.
- c_wdata  in  32  CPU write data.
- c_gnt  out  1  combinational accept; a transfer occurs on the rising edge where c_req & c_gnt.
- c_rdata  out  32  CPU read data, valid while c_rvalid.
- c_rvalid  out  1  one-cycle pulse carrying read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rdata, d_rvalid: same as the C-port signals, for the DMA port.
- mem_addr  out  32  registered memory address, {zeros, ADDR_W index}.
- mem_re  out  1  registered read strobe.
- mem_we  out  1  registered write strobe.
- mem_wdata  out  32  registered write data.
- mem_rd_data  in  32  memory read data, valid before the rising edge that ends the cycle mem_re is high.

## Operation
- Grant logic (combinational, forced 0 while rst_n low):
  - If streak == MAX_STREAK and d_req: d_gnt=1, c_gnt=0.
  - Else if c_req: c_gnt=1, d_gnt=0.
  - Else if d_req: d_gnt=1.
  - At most one gnt is ever high.
- Issue register: on a transfer edge, load mem_addr, mem_we=we, mem_re=~we and mem_wdata from the winner. Record owner (C/D) and is_read.
  - With no transfer, mem_re=mem_we=0. mem_addr and mem_wdata hold their values.
  - mem_re & mem_we is never 1.
- Streak counter, 8 bits:
  - Increments on a C transfer while d_req=1.
  - Clears on any D transfer, or on any edge with d_req=0.
  - Saturates at MAX_STREAK.
- Response: at the rising edge ending an issue cycle with is_read, capture mem_rd_data into the owner's rdata and pulse that owner's rvalid for exactly one cycle.
  - rdata holds until the next read for that port.
  - Writes produce no rvalid.
- Ordering: commands reach memory in grant order. A read granted immediately after a write to the same address returns the new data.
- Reset mid-operation:
  - All registered outputs clear immediately.
  - The in-flight owner/is_read are discarded; no rvalid follows reset release.
  - The streak counter clears.

## Timing
- Reset values: mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, c_rdata=d_rdata=0, c_rvalid=d_rvalid=0, streak=0.
- Cycle N: req high and gnt high → transfer at edge E(N).
- Cycle N+1: mem_* drive the command; memory acts on the clk-low phase.
- Cycle N+2: read data is captured at E(N+1), so rvalid=1 during N+2. Read latency is 2 edges from accept.
- Throughput is one access per cycle total. Back-to-back grants pipeline, so rvalid can be high on consecutive cycles.
- When both ports request every cycle, the grant pattern is MAX_STREAK C-transfers then 1 D-transfer, repeating.
- Requesters may change fields or drop req only after their accept edge. Dropping req before gnt is legal (the request is abandoned, nothing is issued).

## Test plan
- Reset: assert rst_n=0 mid-read (mem_re=1) → all outputs 0 asynchronously; after release, no rvalid and mem_re=0.
- Single CPU write then read: write 0xDEADBEEF to 0x0010, then read 0x0010 on the next cycle.
  - Required: mem_we=1 in cycle 1 and mem_re=1 in cycle 2.
  - Required: c_rvalid in cycle 3 with c_rdata=0xDEADBEEF, and d_rvalid stays 0.
- Priority: C and D both request a read in the same cycle → c_gnt=1, d_gnt=0; D is granted the following cycle; c_rvalid and d_rvalid occur in consecutive cycles with the correct data.
- Starvation (MAX_STREAK=4): C and D requesting continuously → grant sequence C,C,C,C,D,C,C,C,C,D; the streak counter never exceeds 4.
- Address truncation: d_addr=0xFFFF_0003 → mem_addr=0x0000_0003.
- Mutual exclusion and idle: random traffic for 10k cycles → mem_re&mem_we never 1; no transfer implies mem_re=mem_we=0; the rvalid count equals the number of granted reads per port.
